mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter RAM_AW, default 17, RAM address width in bits (128 KiB byte RAM).
REQ-002 Parameter TX_DEPTH, default 8, UART TX FIFO depth; power of two, at least 4.
REQ-003 clk_in  input  1  system clock; all state is updated on the rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 rdy_in  input  1  global ready; when low, the block takes no action.
REQ-006 mem_a  input  32  byte address from the CPU memory adapter; only bits 17:0 are decoded.
REQ-007 mem_wr  input  1  1 = write, 0 = read.
REQ-008 mem_dout  input  8  write data from the CPU side.
REQ-009 mem_din  output  8  read data to the CPU side.
REQ-010 io_buffer_full  output  1  TX FIFO almost-full indication.
REQ-011 uart_tx_data  output  8  byte at the head of the TX FIFO.
REQ-012 uart_tx_valid  output  1  TX FIFO is not empty.
REQ-013 uart_tx_ready  input  1  sink accepts the head byte when valid && ready.
REQ-014 uart_rx_data  input  8  incoming UART byte.
REQ-015 uart_rx_valid  input  1  incoming byte is present.
REQ-016 uart_rx_ready  output  1  high when the RX holding register is empty.
REQ-017 halt  output  1  sticky; set by a write to the halt address.
REQ-018 tx_overflow  output  1  sticky; set when a TX write is dropped.

Function
REQ-019 Address decode: mem_a[17:16]==2'b11 selects IO space; every other address selects RAM at mem_a[RAM_AW-1:0].
REQ-020 Every cycle with rdy_in high carries exactly one access: a read or a write, as given by mem_wr.
REQ-021 RAM write: mem_dout is stored at the addressed byte at the clock edge.
REQ-022 RAM read has 1-cycle latency: mem_din holds the addressed byte in the cycle after mem_a is presented, and stays registered until the next accepted read.
REQ-023 A read in the cycle immediately after a write to the same address returns the newly written byte.
REQ-024 IO 0x30000 write: pushes mem_dout into the TX FIFO.
REQ-025 IO 0x30000 write when the FIFO holds TX_DEPTH entries: the byte is dropped, the FIFO is unchanged, and tx_overflow is set.
REQ-026 IO 0x30000 read: the next-cycle mem_din is the RX holding byte, and the holding register is cleared.
REQ-027 IO 0x30000 read with the holding register empty: mem_din returns 8'h00.
REQ-028 IO 0x30004 read: mem_din = {6'b0, rx_full, tx_fifo_full}, with 1-cycle latency.
REQ-029 IO 0x30004 write: sets halt; the data value is ignored.
REQ-030 Other IO reads return 8'h00; other IO writes are ignored.
REQ-031 io_buffer_full = (FIFO count >= TX_DEPTH-2); this margin covers the adapter's in-flight bytes.
REQ-032 The TX FIFO pops when uart_tx_valid && uart_tx_ready.
REQ-033 A push and a pop in the same cycle leave the count unchanged; both occur.
REQ-034 A push to an empty FIFO makes uart_tx_valid high in the next cycle; there is no bypass.
REQ-035 FIFO read/write pointers wrap modulo TX_DEPTH; the count ranges 0..TX_DEPTH.
REQ-036 The RX holding register captures uart_rx_data when uart_rx_valid && uart_rx_ready.
REQ-037 A CPU read of 0x30000 in the same cycle as an RX capture into an empty register returns 00, and the new byte stays held.
REQ-038 rdy_in low: no RAM write, no FIFO push, no RX pop, no halt set, and mem_din holds its value.
REQ-039 rdy_in low: UART TX pops and RX captures still proceed.

Reset
REQ-040 While rst_in is 0: mem_din=00, the FIFO is empty (pointers and count 0), uart_tx_valid=0, io_buffer_full=0, the RX register is empty, uart_rx_ready=1, halt=0, tx_overflow=0.
REQ-041 RAM contents are not affected by reset.
REQ-042 Reset asserted mid-operation discards queued TX bytes and any held RX byte immediately (asynchronously).

Verification
REQ-043 Write 0x5A to 0x00100, then read 0x00100 in the next cycle -> mem_din=0x5A one cycle later.
REQ-044 With TX_DEPTH=8 and uart_tx_ready=0, perform 8 writes to 0x30000 -> io_buffer_full rises after the 6th push; a 9th write sets tx_overflow and the count stays 8.
REQ-045 Push 0x41,0x42,0x43, then hold uart_tx_ready=1 -> uart_tx_data sequence 41,42,43, then uart_tx_valid=0.
REQ-046 Drive rx byte 0x37 -> uart_rx_ready=0; read 0x30004 -> 0x02; read 0x30000 -> 0x37; uart_rx_ready=1.
REQ-047 Hold rdy_in=0 during a write of 0xFF to 0x00010 and a write to 0x30004 -> RAM[0x10] unchanged and halt=0; with rdy_in=1 the halt write sets halt=1.
REQ-048 Drop rst_in low with 3 bytes queued -> uart_tx_valid=0 and io_buffer_full=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_responder.sv
// Memory/IO responder: byte RAM plus a UART TX FIFO, an RX holding register and halt/overflow flags.
// Latency: reads return on mem_din one cycle after the address; a TX push is visible on the UART side next cycle.
// Backpressure: none toward the CPU. io_buffer_full warns early, and a TX write into a full FIFO is dropped and flagged.
module mem_responder #(
    parameter int RAM_AW   = 17,
    parameter int TX_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic        halt,
    output logic        tx_overflow
);

    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [17:0]   UART_DATA_ADDR = 18'h30000;
    localparam logic [17:0]   UART_CTRL_ADDR = 18'h30004;
    localparam logic [CW-1:0] FIFO_FULL_CNT  = CW'(TX_DEPTH);
    // Two entries of slack, because the CPU adapter may already have bytes in flight when it sees the flag.
    localparam logic [CW-1:0] FIFO_HIGH_CNT  = CW'(TX_DEPTH - 2);

    // ------------------------------------------------------------------
    // Address decode and access qualification
    // ------------------------------------------------------------------
    logic [17:0]       dec_addr;
    logic              io_sel;
    logic              is_data_port;
    logic              is_ctrl_port;
    logic              rd_acc;
    logic              wr_acc;
    logic [RAM_AW-1:0] ram_addr;
    logic              unused_hi_addr;

    assign dec_addr       = mem_a[17:0];
    assign io_sel         = (dec_addr[17:16] == 2'b11);
    assign is_data_port   = (dec_addr == UART_DATA_ADDR);
    assign is_ctrl_port   = (dec_addr == UART_CTRL_ADDR);
    assign rd_acc         = rdy_in && !mem_wr;
    assign wr_acc         = rdy_in && mem_wr;
    assign ram_addr       = mem_a[RAM_AW-1:0];
    // Upper address bits are not decoded; addresses alias every 256 KiB.
    assign unused_hi_addr = ^mem_a[31:18];

    // ------------------------------------------------------------------
    // Byte RAM (no reset: contents survive reset)
    // ------------------------------------------------------------------
    logic [7:0] ram [0:(1 << RAM_AW) - 1];
    logic       ram_we;

    assign ram_we = wr_acc && !io_sel;

    // Store the CPU byte at the addressed location.
    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram[ram_addr] <= mem_dout;
        end
    end

    // ------------------------------------------------------------------
    // UART TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    tx_buf [TX_DEPTH];
    logic [PW-1:0] tx_wr_ptr;
    logic [PW-1:0] tx_rd_ptr;
    logic [CW-1:0] tx_count;
    logic          tx_full;
    logic          tx_push;
    logic          tx_drop;
    logic          tx_pop;

    assign tx_full        = (tx_count == FIFO_FULL_CNT);
    assign tx_push        = wr_acc && is_data_port && !tx_full;
    // A full FIFO drops the byte even if a pop frees a slot in the same cycle.
    assign tx_drop        = wr_acc && is_data_port && tx_full;
    assign uart_tx_valid  = (tx_count != '0);
    assign tx_pop         = uart_tx_valid && uart_tx_ready;
    assign uart_tx_data   = tx_buf[tx_rd_ptr];
    assign io_buffer_full = (tx_count >= FIFO_HIGH_CNT);

    // Write accepted TX bytes into storage. The data array needs no reset because the count qualifies it.
    always_ff @(posedge clk_in) begin
        if (tx_push) begin
            tx_buf[tx_wr_ptr] <= mem_dout;
        end
    end

    // Advance the FIFO pointers and count. Pointers wrap naturally because TX_DEPTH is a power of two.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + PW'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + PW'(1);
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CW'(1);
                2'b01:   tx_count <= tx_count - CW'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // UART RX holding register
    // ------------------------------------------------------------------
    logic       rx_full;
    logic [7:0] rx_dat;
    logic       rx_capture;
    logic       rx_take;

    assign uart_rx_ready = !rx_full;
    assign rx_capture    = uart_rx_valid && uart_rx_ready;
    assign rx_take       = rd_acc && is_data_port;

    // Capture only into an empty register. A CPU read that races a capture sees the old (empty) state,
    // and the new byte is kept for the next read.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_full <= 1'b0;
            rx_dat  <= 8'h00;
        end else if (rx_capture) begin
            rx_full <= 1'b1;
            rx_dat  <= uart_rx_data;
        end else if (rx_take) begin
            rx_full <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    logic [7:0] rd_next;

    // Select the byte returned for this cycle's read, based on pre-edge state.
    always_comb begin
        rd_next = 8'h00;
        if (!io_sel) begin
            rd_next = ram[ram_addr];
        end else if (is_data_port) begin
            rd_next = rx_full ? rx_dat : 8'h00;
        end else if (is_ctrl_port) begin
            rd_next = {6'b0, rx_full, tx_full};
        end
    end

    // Register read data. It only changes on an accepted read and holds otherwise.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_din <= 8'h00;
        end else if (rd_acc) begin
            mem_din <= rd_next;
        end
    end

    // ------------------------------------------------------------------
    // Sticky status flags
    // ------------------------------------------------------------------

    // Halt on any write to the control address, and flag dropped TX bytes. Both flags clear only on reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            halt        <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            if (wr_acc && is_ctrl_port) begin
                halt <= 1'b1;
            end
            if (tx_drop) begin
                tx_overflow <= 1'b1;
            end
        end
    end

endmodule
